// File: rtl/grc_burst_ctrl.sv
// Command-driven burst sequencer that steps a binary count and presents it Gray-coded on out.
// Optional GRC_BURST_SAT_EN: saturate at the count limits (early done, no wrap) instead of wrapping.
module grc_burst_ctrl #(
    parameter int N     = 4,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [N-1:0]     cmd_start,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_dir,
    input  logic             pause,
    input  logic             abort,
    output logic [N-1:0]     out,
    output logic             busy,
    output logic             done,
    output logic             wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [N-1:0]     BIN_ONE = N'(1);
    localparam logic [N-1:0]     BIN_MAX = '1;
    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

    state_t             r_state;
    logic [N-1:0]       r_bin;
    logic [N-1:0]       r_out;
    logic [LEN_W-1:0]   r_rem;
    logic               r_dir;
    logic               r_done;
    logic               r_wrap;

    logic [N-1:0]       w_binNext;
    logic               w_atLimit;
    logic               w_accept;
    logic               w_lastStep;

    function automatic logic [N-1:0] toGray(input logic [N-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // A step is "at the limit" when it would cross the modulo boundary in the latched direction.
    assign w_binNext  = r_dir ? (r_bin - BIN_ONE) : (r_bin + BIN_ONE);
    assign w_atLimit  = r_dir ? (r_bin == '0) : (r_bin == BIN_MAX);
    assign w_lastStep = (r_rem == LEN_ONE);

    assign cmd_ready = (r_state == IDLE) && !rst;
    assign w_accept  = cmd_valid && cmd_ready;

    assign out  = r_out;
    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign wrap = r_wrap;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_bin   <= '0;
            r_out   <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_bin <= cmd_start;
                        r_out <= toGray(cmd_start);
                        r_rem <= cmd_len;
                        r_dir <= cmd_dir;
                        if (cmd_len != '0) begin
                            r_state <= RUN;
                        end else begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    // Abort outranks pause and suppresses both the step and the done pulse.
                    if (abort) begin
                        r_state <= IDLE;
                    end else if (!pause) begin
`ifdef GRC_BURST_SAT_EN
                        if (w_atLimit) begin
                            r_rem   <= '0;
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_bin <= w_binNext;
                            r_out <= toGray(w_binNext);
                            r_rem <= r_rem - LEN_ONE;
                            if (w_lastStep) begin
                                r_state <= DONE;
                                r_done  <= 1'b1;
                            end
                        end
`else
                        r_bin  <= w_binNext;
                        r_out  <= toGray(w_binNext);
                        r_rem  <= r_rem - LEN_ONE;
                        r_wrap <= w_atLimit;
                        if (w_lastStep) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end
`endif
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grc_burst_ctrl.sv
// Directed self-checking bench for grc_burst_ctrl (N=4, LEN_W=8); honours GRC_BURST_SAT_EN.
module tb_grc_burst_ctrl;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_start;
    logic [7:0] cmd_len;
    logic       cmd_dir;
    logic       pause;
    logic       abort;
    logic [3:0] out;
    logic       busy;
    logic       done;
    logic       wrap;

    int assertCount = 0;
    int failCount   = 0;

    grc_burst_ctrl #(.N(4), .LEN_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_len   (cmd_len),
        .cmd_dir   (cmd_dir),
        .pause     (pause),
        .abort     (abort),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for exactly one edge; returns with outputs reflecting the accept.
    task automatic applyCommand(input logic [3:0] start, input logic [7:0] len, input logic dir);
        cmd_start = start;
        cmd_len   = len;
        cmd_dir   = dir;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        assertCount++;
        if (cmd_ready !== 1'b0) begin failCount++; $display("[TB] FAIL reset_ready_in_rst: got %b expected 0", cmd_ready); end
        rst = 1'b0;
        tick();
        assertCount++;
        if (out !== 4'h0) begin failCount++; $display("[TB] FAIL reset_out: got %h expected 0", out); end
        assertCount++;
        if ({busy, done, wrap} !== 3'b000) begin failCount++; $display("[TB] FAIL reset_flags: got %b expected 000", {busy, done, wrap}); end
        assertCount++;
        if (cmd_ready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_count_up();
        logic [3:0] expOut [5];
        logic [3:0] prev;
        expOut = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7};
        applyCommand(4'd0, 8'd5, 1'b0);
        assertCount++;
        if (out !== 4'h0 || busy !== 1'b1 || cmd_ready !== 1'b0) begin
            failCount++; $display("[TB] FAIL up_accept: got out=%h busy=%b ready=%b expected 0/1/0", out, busy, cmd_ready);
        end
        prev = out;
        for (int i = 0; i < 5; i++) begin
            tick();
            assertCount++;
            if (out !== expOut[i]) begin failCount++; $display("[TB] FAIL up_out[%0d]: got %h expected %h", i, out, expOut[i]); end
            assertCount++;
            if ($countones(out ^ prev) !== 1) begin failCount++; $display("[TB] FAIL up_onebit[%0d]: got %h->%h expected 1-bit change", i, prev, out); end
            assertCount++;
            if (done !== (i == 4) || wrap !== 1'b0) begin
                failCount++; $display("[TB] FAIL up_done[%0d]: got done=%b wrap=%b expected %b/0", i, done, wrap, (i == 4));
            end
            prev = out;
        end
        tick();
        assertCount++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || out !== 4'h7) begin
            failCount++; $display("[TB] FAIL up_idle: got ready=%b busy=%b done=%b out=%h expected 1/0/0/7", cmd_ready, busy, done, out);
        end
    endtask

    task automatic test_wrap_up();
        applyCommand(4'd14, 8'd3, 1'b0);
        assertCount++;
        if (out !== 4'h9) begin failCount++; $display("[TB] FAIL wrapup_accept: got %h expected 9", out); end
        tick();
        assertCount++;
        if (out !== 4'h8 || wrap !== 1'b0) begin failCount++; $display("[TB] FAIL wrapup_s1: got out=%h wrap=%b expected 8/0", out, wrap); end
        tick();
`ifdef GRC_BURST_SAT_EN
        assertCount++;
        if (out !== 4'h8 || wrap !== 1'b0 || done !== 1'b1) begin
            failCount++; $display("[TB] FAIL wrapup_sat: got out=%h wrap=%b done=%b expected 8/0/1", out, wrap, done);
        end
        tick();
        assertCount++;
        if (busy !== 1'b0 || out !== 4'h8) begin failCount++; $display("[TB] FAIL wrapup_sat_idle: got busy=%b out=%h expected 0/8", busy, out); end
`else
        assertCount++;
        if (out !== 4'h0 || wrap !== 1'b1 || done !== 1'b0) begin
            failCount++; $display("[TB] FAIL wrapup_s2: got out=%h wrap=%b done=%b expected 0/1/0", out, wrap, done);
        end
        tick();
        assertCount++;
        if (out !== 4'h1 || wrap !== 1'b0 || done !== 1'b1) begin
            failCount++; $display("[TB] FAIL wrapup_s3: got out=%h wrap=%b done=%b expected 1/0/1", out, wrap, done);
        end
        tick();
`endif
    endtask

    task automatic test_wrap_down();
        applyCommand(4'd1, 8'd2, 1'b1);
        assertCount++;
        if (out !== 4'h1) begin failCount++; $display("[TB] FAIL down_accept: got %h expected 1", out); end
        tick();
        assertCount++;
        if (out !== 4'h0 || wrap !== 1'b0) begin failCount++; $display("[TB] FAIL down_s1: got out=%h wrap=%b expected 0/0", out, wrap); end
        tick();
`ifdef GRC_BURST_SAT_EN
        assertCount++;
        if (out !== 4'h0 || wrap !== 1'b0 || done !== 1'b1) begin
            failCount++; $display("[TB] FAIL down_sat: got out=%h wrap=%b done=%b expected 0/0/1", out, wrap, done);
        end
`else
        assertCount++;
        if (out !== 4'h8 || wrap !== 1'b1 || done !== 1'b1) begin
            failCount++; $display("[TB] FAIL down_s2: got out=%h wrap=%b done=%b expected 8/1/1", out, wrap, done);
        end
`endif
        tick();
        assertCount++;
        if (busy !== 1'b0 || wrap !== 1'b0) begin failCount++; $display("[TB] FAIL down_idle: got busy=%b wrap=%b expected 0/0", busy, wrap); end
    endtask

    task automatic test_pause();
        logic [3:0] expOut [7];
        logic [6:0] expDone;
        logic [6:0] pauseCfg;
        expOut   = '{4'h1, 4'h3, 4'h3, 4'h3, 4'h3, 4'h2, 4'h6};
        expDone  = 7'b1000000;
        pauseCfg = 7'b0011100;
        applyCommand(4'd0, 8'd4, 1'b0);
        for (int i = 0; i < 7; i++) begin
            pause = pauseCfg[i];
            tick();
            assertCount++;
            if (out !== expOut[i] || done !== expDone[i] || busy !== 1'b1) begin
                failCount++; $display("[TB] FAIL pause[%0d]: got out=%h done=%b busy=%b expected %h/%b/1", i, out, done, busy, expOut[i], expDone[i]);
            end
        end
        pause = 1'b0;
        tick();
        assertCount++;
        if (cmd_ready !== 1'b1) begin failCount++; $display("[TB] FAIL pause_idle: got ready=%b expected 1", cmd_ready); end
    endtask

    task automatic test_zero_len();
        // Abort is held throughout: it must be ignored in IDLE and in DONE.
        abort = 1'b1;
        applyCommand(4'd6, 8'd0, 1'b0);
        assertCount++;
        if (out !== 4'h5 || done !== 1'b1 || busy !== 1'b1) begin
            failCount++; $display("[TB] FAIL zero_accept: got out=%h done=%b busy=%b expected 5/1/1", out, done, busy);
        end
        tick();
        assertCount++;
        if (out !== 4'h5 || done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            failCount++; $display("[TB] FAIL zero_idle: got out=%h done=%b busy=%b ready=%b expected 5/0/0/1", out, done, busy, cmd_ready);
        end
        abort = 1'b0;
    endtask

    task automatic test_abort();
        applyCommand(4'd0, 8'd8, 1'b0);
        tick();
        tick();
        assertCount++;
        if (out !== 4'h3) begin failCount++; $display("[TB] FAIL abort_pre: got %h expected 3", out); end
        abort = 1'b1;
        pause = 1'b1;
        tick();
        abort = 1'b0;
        pause = 1'b0;
        assertCount++;
        if (out !== 4'h3 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            failCount++; $display("[TB] FAIL abort_post: got out=%h busy=%b done=%b ready=%b expected 3/0/0/1", out, busy, done, cmd_ready);
        end
        tick();
        assertCount++;
        if (out !== 4'h3 || done !== 1'b0) begin failCount++; $display("[TB] FAIL abort_hold: got out=%h done=%b expected 3/0", out, done); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] expOut [6];
        logic [5:0] expReady;
        applyCommand(4'd2, 8'd2, 1'b0);
        cmd_valid = 1'b1;
        cmd_start = 4'd9;
        cmd_len   = 8'd1;
        cmd_dir   = 1'b0;
        assertCount++;
        if (out !== 4'h3) begin failCount++; $display("[TB] FAIL b2b_accept: got %h expected 3", out); end
        expOut   = '{4'h2, 4'h6, 4'h6, 4'hD, 4'hF, 4'hF};
        expReady = 6'b100100;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (i == 3) cmd_valid = 1'b0;
            assertCount++;
            if (out !== expOut[i] || cmd_ready !== expReady[i]) begin
                failCount++; $display("[TB] FAIL b2b[%0d]: got out=%h ready=%b expected %h/%b", i, out, cmd_ready, expOut[i], expReady[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        applyCommand(4'd5, 8'd8, 1'b0);
        tick();
        assertCount++;
        if (out !== 4'h5) begin failCount++; $display("[TB] FAIL midrst_pre: got %h expected 5", out); end
        #2;
        rst = 1'b1;
        #1;
        assertCount++;
        if (out !== 4'h0 || busy !== 1'b0) begin failCount++; $display("[TB] FAIL midrst_async: got out=%h busy=%b expected 0/0", out, busy); end
        tick();
        rst = 1'b0;
        tick();
        assertCount++;
        if (out !== 4'h0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failCount++; $display("[TB] FAIL midrst_after: got out=%h ready=%b busy=%b expected 0/1/0", out, cmd_ready, busy);
        end
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_len   = '0;
        cmd_dir   = 1'b0;
        pause     = 1'b0;
        abort     = 1'b0;
        test_reset();
        test_count_up();
        test_wrap_up();
        test_wrap_down();
        test_pause();
        test_zero_len();
        test_abort();
        test_back_to_back();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
